// File: rtl/hazard_pkg.sv
// Shared forward-select encodings for the hazard/forwarding scoreboard.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // MEM wins over WB: it holds the younger result for the same register.
  function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit) return FWD_MEM;
    if (wb_hit) return FWD_WB;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_fwd_scoreboard_sb_entry.sv
// One scoreboard entry: latency down-counter; busy while the count is nonzero.
module sb_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LAT_W-1:0] lat,
  output logic             busy,
  output logic             expiring
);

  logic [LAT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= lat;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy     = (cnt != '0);
  assign expiring = (cnt == LAT_W'(1));

endmodule

// File: rtl/hazard_fwd_scoreboard.sv
// Operand forwarding, load-use / scoreboard RAW / WAW stall detection and long-op busy tracking.
// Optional perf counters (stall_cycles, fwd_events) when HAZARD_PERF_CNT_EN is defined.
module hazard_fwd_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int LAT_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
  input  logic                      ex_mem_read,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic                      mem_reg_write,
  input  logic                      wb_reg_write,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_rd,
  input  logic [LAT_W-1:0]          issue_lat,
  output logic [NUM_SRC*2-1:0]      forward_sel,
  output logic                      stall,
  output logic [2**REG_AW-1:0]      busy_vec
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               fwd_events
`endif
);

  localparam int NREG = 2**REG_AW;

  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   expiring;
  logic [REG_AW-1:0] ex_src;
  logic [REG_AW-1:0] id_src;
  logic              load_use;
  logic              raw_hazard;
  logic              waw_hazard;
  logic              issue_take;

  always_comb begin
    forward_sel = '0;
    ex_src      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ex_src = ex_rs[i*REG_AW +: REG_AW];
      forward_sel[i*2 +: 2] = fwd_pick(mem_reg_write && (mem_rd != '0) && (mem_rd == ex_src),
                                       wb_reg_write && (wb_rd != '0) && (wb_rd == ex_src));
    end
  end

  always_comb begin
    load_use   = 1'b0;
    raw_hazard = 1'b0;
    id_src     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      id_src = id_s_sel(i);
      if (id_src != '0) begin
        if (ex_mem_read && (ex_rd == id_src)) load_use = 1'b1;
        if (busy[id_src]) raw_hazard = 1'b1;
      end
    end
    load_use   = load_use && id_valid;
    raw_hazard = raw_hazard && id_valid;
  end

  function automatic logic [REG_AW-1:0] id_s_sel(input int idx);
    return id_rs[idx*REG_AW +: REG_AW];
  endfunction

  // A register whose counter expires on this edge is free to be re-issued on the same edge.
  assign waw_hazard = issue_valid && (issue_rd != '0) && busy[issue_rd] && !expiring[issue_rd];
  assign stall      = load_use || raw_hazard || waw_hazard;
  assign issue_take = issue_valid && !stall && (issue_rd != '0) && (issue_lat != '0);

  assign busy[0]     = 1'b0;
  assign expiring[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    sb_entry #(
      .LAT_W (LAT_W)
    ) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (issue_take && (issue_rd == REG_AW'(r))),
      .lat      (issue_lat),
      .busy     (busy[r]),
      .expiring (expiring[r])
    );
  end

  assign busy_vec = busy;

`ifdef HAZARD_PERF_CNT_EN
  logic fwd_any;
  assign fwd_any = |forward_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      fwd_events   <= '0;
    end else begin
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (fwd_any && (fwd_events != '1)) fwd_events <= fwd_events + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_fwd_scoreboard.md
HAZARD_FWD_SCOREBOARD -- requirements
Module: hazard_fwd_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 4, meaning register-address width; 2**REG_AW architectural registers.
REQ-002 SHALL have parameter NUM_SRC, default 2, meaning source operands per instruction.
REQ-003 SHALL have parameter LAT_W, default 3, meaning long-op latency field width; maximum latency 2**LAT_W-1 cycles.
REQ-004 SHALL provide ports, one per line (name  direction  width  meaning):
  clk  in  1  single clock, rising edge.
  rst_n  in  1  asynchronous active-low reset.
  id_valid  in  1  decode-stage instruction valid.
  id_rs  in  NUM_SRC*REG_AW  decode sources, operand i at [i*REG_AW +: REG_AW].
  ex_rs  in  NUM_SRC*REG_AW  execute-stage sources, same packing.
  ex_mem_read  in  1  EX instruction is a load.
  ex_rd  in  REG_AW  EX destination.
  mem_rd, wb_rd  in  REG_AW  MEM/WB destinations.
  mem_reg_write, wb_reg_write  in  1  MEM/WB write enables.
  issue_valid  in  1  long-latency op leaving decode.
  issue_rd  in  REG_AW  long-op destination.
  issue_lat  in  LAT_W  long-op latency in cycles.
  forward_sel  out  NUM_SRC*2  per-operand select, 00 regfile, 10 MEM, 01 WB.
  stall  out  1  hold PC/IF/ID and insert bubble into EX.
  busy_vec  out  2**REG_AW  registered scoreboard busy bits.

Function
REQ-005 SHALL drive forward_sel for operand i = 10 when mem_reg_write, mem_rd!=0 and mem_rd==ex_rs[i]; else 01 when wb_reg_write, wb_rd!=0 and wb_rd==ex_rs[i]; else 00 (combinational, zero latency).
REQ-006 SHALL never forward or stall on register 0.
REQ-007 SHALL assert stall (load-use) when id_valid, ex_mem_read, ex_rd!=0 and ex_rd equals any id_rs operand.
REQ-008 SHALL assert stall (scoreboard RAW) when id_valid and any nonzero id_rs operand has busy_vec bit set.
REQ-009 SHALL assert stall (WAW) when issue_valid, issue_rd!=0 and busy_vec[issue_rd] is set.
REQ-010 SHALL, on a clock edge with issue_valid, !stall, issue_rd!=0 and issue_lat!=0, set busy_vec[issue_rd] and load its counter with issue_lat.
REQ-011 SHALL ignore issues with issue_lat==0 or issue_rd==0 (no state change).
REQ-012 SHALL decrement every nonzero counter by one per cycle, independent of stall; a counter reaching 0 clears its busy bit on that same edge.
REQ-013 SHALL, when an issue targets a register whose counter reaches 0 on the same edge, take the new issue (set bit, load issue_lat).
REQ-014 SHALL evaluate stall combinationally from current inputs and registered busy_vec only; the cycle after a busy bit clears, the dependent source no longer stalls.

Reset
REQ-015 SHALL, on rst_n low, asynchronously clear all counters and busy_vec; forward_sel then equals its REQ-005 function of inputs, and stall is low unless REQ-007 holds.
REQ-016 SHALL abandon in-flight long ops on reset mid-operation; no busy bit survives reset.

Configuration
REQ-017 SHALL, with macro HAZARD_PERF_CNT_EN defined, add outputs stall_cycles (32-bit) and fwd_events (32-bit), reset to 0, counting cycles with stall high and cycles with any forward_sel!=00, saturating at all-ones.
REQ-018 SHALL, without HAZARD_PERF_CNT_EN, omit both ports and their registers entirely.

Structure
REQ-019 SHALL place the forward-select encodings (FWD_NONE=00, FWD_WB=01, FWD_MEM=10) in shared package hazard_pkg.
REQ-020 SHALL implement per-register busy/counter state as sub-module sb_entry (instantiated 2**REG_AW-1 times; register 0 tied idle).

Verification
REQ-021 SHALL check: mem_rd=3, mem_reg_write=1, wb_rd=3, wb_reg_write=1, ex_rs[0]=3 -> forward_sel[1:0]=10 (MEM priority).
REQ-022 SHALL check: ex_mem_read=1, ex_rd=5, id_valid=1, id_rs[1]=5 -> stall=1 for that cycle; with ex_rd=0 -> stall=0.
REQ-023 SHALL check: issue rd=7, lat=3 -> busy_vec[7] high for exactly 3 edges; id_rs[0]=7 stalls for those cycles, clears after.
REQ-024 SHALL check: second issue to rd=7 while busy -> stall=1 and counter unchanged; issue timed on the clearing edge -> accepted, busy reloaded.
REQ-025 SHALL check: rst_n pulsed low mid-countdown -> busy_vec=0 immediately, asynchronously, before next clk edge.
REQ-026 SHALL check (HAZARD_PERF_CNT_EN): 4 stall cycles and 2 forward cycles -> stall_cycles=4, fwd_events=2.
